// File: rtl/led_status_pkg.sv
// Shared types and constants for the status-LED driver.
package led_status_pkg;

  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    TRAIN = 2'd1,
    UP    = 2'd2
  } link_st_t;

  localparam int LED_HB   = 0;
  localparam int LED_LINK = 1;
  localparam int LED_PCIE = 2;
  localparam int LED_QSPI = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_status_ctrl_if.sv
// Status inputs from the system block and the active-low LED pins.
interface led_status_ctrl_if;
  logic       link_up;
  logic       act_pcie;
  logic       act_qspi;
  logic       err;
  logic       err_clr;
  logic [3:0] ledn;

  modport master (output link_up, act_pcie, act_qspi, err, err_clr, input ledn);
  modport slave  (input link_up, act_pcie, act_qspi, err, err_clr, output ledn);
endinterface

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher: active for LEN cycles after the latest pulse.
module pulse_stretch #(
  parameter int LEN = 4194304
) (
  input  logic clk,
  input  logic rstn,
  input  logic pulse,
  output logic active
);

  localparam int              CW    = $clog2(LEN + 1);
  localparam logic [CW-1:0]   LEN_V = CW'(LEN);

  logic [CW-1:0] cnt_r;

  // Reload on pulse, otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= '0;
    end else if (pulse) begin
      cnt_r <= LEN_V;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign active = (cnt_r != '0);

endmodule

// File: rtl/led_status_ctrl.sv
// Four-LED status driver: heartbeat, PCIe link, PCIe and QSPI activity.
// Optional sticky error blink on all LEDs when LED_ERR_LATCH_EN is defined.
import led_status_pkg::*;

module led_status_ctrl #(
  parameter int HB_BIT      = 24,
  parameter int FAST_BIT    = 21,
  parameter int STRETCH_CYC = 4194304,
  parameter int TRAIN_CYC   = 33554432
) (
  input logic               clk,
  input logic               rstn,
  led_status_ctrl_if.slave  bus
);

  localparam int            CW         = max2(HB_BIT, FAST_BIT) + 1;
  localparam int            TW         = (TRAIN_CYC > 1) ? $clog2(TRAIN_CYC) : 1;
  localparam logic [TW-1:0] TRAIN_LOAD = TW'(TRAIN_CYC - 1);

  logic [CW-1:0] cnt_r;
  logic [1:0]    link_sync_r;
  logic          link_s;
  link_st_t      st_r, st_nxt_s;
  logic [TW-1:0] tcnt_r, tcnt_nxt_s;
  logic          pcie_act_s, qspi_act_s;
  logic [3:0]    led_norm_s, led_s;
  logic [3:0]    ledn_r;

  // Free-running blink time base.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // link_up comes from another clock domain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      link_sync_r <= 2'b00;
    end else begin
      link_sync_r <= {link_sync_r[0], bus.link_up};
    end
  end

  assign link_s = link_sync_r[1];

  // Link FSM state and training-window counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_r   <= DOWN;
      tcnt_r <= '0;
    end else begin
      st_r   <= st_nxt_s;
      tcnt_r <= tcnt_nxt_s;
    end
  end

  // Link FSM next state; a dropped link wins over training completion.
  always_comb begin
    st_nxt_s   = st_r;
    tcnt_nxt_s = tcnt_r;
    case (st_r)
      DOWN: begin
        if (link_s) begin
          st_nxt_s   = TRAIN;
          tcnt_nxt_s = TRAIN_LOAD;
        end else begin
          st_nxt_s   = DOWN;
        end
      end
      TRAIN: begin
        if (!link_s) begin
          st_nxt_s   = DOWN;
        end else if (tcnt_r == '0) begin
          st_nxt_s   = UP;
        end else begin
          tcnt_nxt_s = tcnt_r - TW'(1);
        end
      end
      UP: begin
        if (!link_s) begin
          st_nxt_s = DOWN;
        end else begin
          st_nxt_s = UP;
        end
      end
      default: begin
        st_nxt_s   = DOWN;
        tcnt_nxt_s = '0;
      end
    endcase
  end

  pulse_stretch #(.LEN(STRETCH_CYC)) u_pcie_stretch (
    .clk    (clk),
    .rstn   (rstn),
    .pulse  (bus.act_pcie),
    .active (pcie_act_s)
  );

  pulse_stretch #(.LEN(STRETCH_CYC)) u_qspi_stretch (
    .clk    (clk),
    .rstn   (rstn),
    .pulse  (bus.act_qspi),
    .active (qspi_act_s)
  );

  // Normal (non-error) LED sources, active high.
  always_comb begin
    led_norm_s           = 4'b0000;
    led_norm_s[LED_HB]   = cnt_r[HB_BIT];
    case (st_r)
      TRAIN:   led_norm_s[LED_LINK] = cnt_r[FAST_BIT];
      UP:      led_norm_s[LED_LINK] = 1'b1;
      default: led_norm_s[LED_LINK] = 1'b0;
    endcase
    led_norm_s[LED_PCIE] = pcie_act_s;
    led_norm_s[LED_QSPI] = qspi_act_s;
  end

`ifdef LED_ERR_LATCH_EN
  logic err_r;

  // Sticky error flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_r <= 1'b0;
    end else if (bus.err) begin
      err_r <= 1'b1;
    end else if (bus.err_clr) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign led_s = err_r ? {4{cnt_r[FAST_BIT]}} : led_norm_s;
`else
  logic unused_err_s;
  assign unused_err_s = ^{bus.err, bus.err_clr};
  assign led_s        = led_norm_s;
`endif

  // Registered active-low pin drive.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ledn_r <= 4'hF;
    end else begin
      ledn_r <= ~led_s;
    end
  end

  assign bus.ledn = ledn_r;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Self-checking bench for led_status_ctrl (scaled-down timing parameters).
import led_status_pkg::*;

module tb_led_status_ctrl;

  localparam int HB  = 4;
  localparam int FB  = 2;
  localparam int SC  = 10;
  localparam int TC  = 16;
  localparam int CNT_MOD = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  led_status_ctrl_if bus ();

  led_status_ctrl #(
    .HB_BIT(HB), .FAST_BIT(FB), .STRETCH_CYC(SC), .TRAIN_CYC(TC)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: n = edges since reset release; state "after edge m".
  int n;
  int last_p, last_q;
  int run_h [0:8191];
  bit latch_m;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: edge %0d got %b expected %b", name, n, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_ledn(input int m);
    logic [3:0] led;
    int c, len;
    c   = m % CNT_MOD;
    len = (m >= 3) ? run_h[m-2] : 0;
    led[0] = c[HB];
    led[1] = (len == 0) ? 1'b0 : ((len <= TC) ? c[FB] : 1'b1);
    led[2] = (m - last_p) < SC;
    led[3] = (m - last_q) < SC;
    if (latch_m) led = {4{c[FB]}};
    return ~led;
  endfunction

  task automatic model_reset();
    n = 0; last_p = -100; last_q = -100; run_h[0] = 0; latch_m = 1'b0;
  endtask

  // One clock: drive at negedge, check just after posedge, then advance model.
  task automatic cyc(input logic ap, input logic aq, input logic lu,
                     input logic e, input logic ec);
    @(negedge clk);
    bus.act_pcie = ap; bus.act_qspi = aq; bus.link_up = lu;
    bus.err = e; bus.err_clr = ec;
    @(posedge clk); #1;
    chk("model", bus.ledn, exp_ledn(n));
    n++;
    if (ap) last_p = n;
    if (aq) last_q = n;
    run_h[n] = lu ? ((run_h[n-1] < 1000) ? run_h[n-1] + 1 : 1000) : 0;
`ifdef LED_ERR_LATCH_EN
    if (e) latch_m = 1'b1;
    else if (ec) latch_m = 1'b0;
`endif
  endtask

  typedef struct {
    logic       ap;
    logic       aq;
    logic [1:0] exp_hi;   // expected ledn[3:2]
  } vec_t;

  vec_t tbl [32];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int toggles, first_tog;
    logic prev0;
    logic lu_r;

    for (int i = 0; i < 32; i++) begin
      tbl[i].ap        = (i == 0);
      tbl[i].aq        = (i == 12) || (i == 18);
      tbl[i].exp_hi[0] = !(i >= 1 && i <= 10);
      tbl[i].exp_hi[1] = !(i >= 13 && i <= 28);
    end

    bus.link_up = 1'b0; bus.act_pcie = 1'b0; bus.act_qspi = 1'b0;
    bus.err = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ledn", bus.ledn, 4'hF);
    rstn = 1'b1;

    // Idle heartbeat
    toggles = 0; first_tog = -1; prev0 = bus.ledn[0];
    for (int i = 0; i < 64; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("idle_hi", {1'b0, bus.ledn[3:1]}, 4'b0111);
      if (bus.ledn[0] != prev0) begin
        toggles++;
        if (first_tog < 0) first_tog = n;
      end
      prev0 = bus.ledn[0];
    end
    chk("hb_toggles", toggles[3:0], 4'd3);
    chk("hb_first", first_tog[3:0], 4'd1);   // 17 mod 16

    // Stretcher vectors
    for (int i = 0; i < 32; i++) begin
      cyc(tbl[i].ap, tbl[i].aq, 1'b0, 1'b0, 1'b0);
      chk("tbl_act", {2'b00, bus.ledn[3:2]}, {2'b00, tbl[i].exp_hi});
    end

    // Back-to-back pulses keep the LED on
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pcie_hold", {3'b000, bus.ledn[2]}, 4'd0);
    repeat (12) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Link up: training blink then solid
    repeat (40) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("link_up_solid", {3'b000, bus.ledn[1]}, 4'd0);
    chk("st_up", {2'b00, u_dut.st_r}, {2'b00, UP});
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("link_down_off", {3'b000, bus.ledn[1]}, 4'd1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Drop during training
    repeat (8) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("st_train", {2'b00, u_dut.st_r}, {2'b00, TRAIN});
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("train_drop_off", {3'b000, bus.ledn[1]}, 4'd1);
    chk("train_drop_st", {2'b00, u_dut.st_r}, {2'b00, DOWN});

    // Error latch (or its absence)
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (16) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (9) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stretch and mid-training
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.link_up = 1'b0;
    #2 rstn = 1'b0;
    #1 chk("async_reset", bus.ledn, 4'hF);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", bus.ledn, 4'hF);
    rstn = 1'b1;
    model_reset();
    chk("rst_st", {2'b00, u_dut.st_r}, {2'b00, DOWN});
    chk("rst_pcie", u_dut.u_pcie_stretch.cnt_r, 4'd0);
    chk("rst_qspi", u_dut.u_qspi_stretch.cnt_r, 4'd0);

    // Randomized traffic against the model
    lu_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49, 0) == 0) lu_r = ~lu_r;
      cyc($urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0, lu_r,
          $urandom_range(59, 0) == 0, $urandom_range(29, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
